// File: rtl/stimer_sched_if.sv
// Supervisor timer compare bus: CSR write strobes, mtime in, compare readback and interrupt out.
interface stimer_sched_if #(
   parameter int unsigned XLEN = 64
);
   logic            StallW;
   logic            STCE;
   logic            WriteSTIMECMPM;
   logic            WriteSTIMECMPHM;
   logic [XLEN-1:0] CSRWriteValM;
   logic [63:0]     MTIME_CLINT;
   logic [63:0]     STIMECMP_REGW;
   logic            STimerInt;

   modport master (
      output StallW, STCE, WriteSTIMECMPM, WriteSTIMECMPHM, CSRWriteValM, MTIME_CLINT,
      input  STIMECMP_REGW, STimerInt
   );

   modport slave (
      input  StallW, STCE, WriteSTIMECMPM, WriteSTIMECMPHM, CSRWriteValM, MTIME_CLINT,
      output STIMECMP_REGW, STimerInt
   );
endinterface

// File: rtl/stimer_sched.sv
// Sstc supervisor timer: owns STIMECMP and raises STimerInt via a two-stage split
// 32-bit compare against mtime, with a short hold-off after every committed write.
module stimer_sched #(
   parameter int unsigned XLEN           = 64,
   parameter bit          SSTC_SUPPORTED = 1'b1
) (
   input logic            clk,
   input logic            reset,
   stimer_sched_if.slave  bus
);
   localparam int unsigned HOLD_W    = 2;
   localparam int unsigned HALF_W    = 32;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(2);

   if (SSTC_SUPPORTED) begin : g_sstc
      logic [63:0]       cmp_q, cmp_d;
      logic              lo_ge_q, hi_gt_q, hi_eq_q;
      logic              lo_ge_d, hi_gt_d, hi_eq_d;
      logic [HOLD_W-1:0] hold_q, hold_d;
      logic              int_q, int_d;
      logic              wr_lo_c, wr_hi_c, commit_c;

      // Write commit, split compare and hold-off next-state logic
      always_comb begin
         wr_lo_c  = bus.STCE & ~bus.StallW & bus.WriteSTIMECMPM;
         wr_hi_c  = (XLEN == 32) & bus.STCE & ~bus.StallW & bus.WriteSTIMECMPHM;
         commit_c = wr_lo_c | wr_hi_c;

         cmp_d = cmp_q;
         if (XLEN == 64) begin
            if (wr_lo_c) cmp_d = 64'(bus.CSRWriteValM);
         end else begin
            if (wr_lo_c) cmp_d[HALF_W-1:0]  = bus.CSRWriteValM[HALF_W-1:0];
            if (wr_hi_c) cmp_d[63:HALF_W]   = bus.CSRWriteValM[HALF_W-1:0];
         end

         lo_ge_d = bus.MTIME_CLINT[HALF_W-1:0] >= cmp_q[HALF_W-1:0];
         hi_gt_d = bus.MTIME_CLINT[63:HALF_W]  >  cmp_q[63:HALF_W];
         hi_eq_d = bus.MTIME_CLINT[63:HALF_W]  == cmp_q[63:HALF_W];

         if (commit_c)                     hold_d = HOLD_LOAD;
         else if (hold_q != HOLD_W'(0))    hold_d = hold_q - HOLD_W'(1);
         else                              hold_d = HOLD_W'(0);

         // Stale stage-1 results are masked until the new deadline has propagated
         int_d = (hi_gt_q | (hi_eq_q & lo_ge_q)) & bus.STCE & (hold_q == HOLD_W'(0));
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            cmp_q   <= '1;
            lo_ge_q <= 1'b0;
            hi_gt_q <= 1'b0;
            hi_eq_q <= 1'b0;
            hold_q  <= HOLD_LOAD;
            int_q   <= 1'b0;
         end else begin
            cmp_q   <= cmp_d;
            lo_ge_q <= lo_ge_d;
            hi_gt_q <= hi_gt_d;
            hi_eq_q <= hi_eq_d;
            hold_q  <= hold_d;
            int_q   <= int_d;
         end
      end

      assign bus.STIMECMP_REGW = cmp_q;
      assign bus.STimerInt     = int_q;
   end else begin : g_inert
      logic unused_inputs;
      assign unused_inputs     = ^{clk, reset, bus.StallW, bus.STCE, bus.WriteSTIMECMPM,
                                   bus.WriteSTIMECMPHM, bus.CSRWriteValM, bus.MTIME_CLINT};
      assign bus.STIMECMP_REGW = '1;
      assign bus.STimerInt     = 1'b0;
   end
endmodule
